// File: rtl/tetris_command_queue.sv
// tetris_command_queue
//   Sits between the SPI receiver and game_executioner in the game_clk domain.
//   Each rising edge of i_byte_strobe (seen while idle) captures i_byte_in and
//   raises o_byte_clear until the SPI side drops its strobe. Captured bytes are
//   decoded into move/piece fields and buffered in a small FIFO. The head entry
//   is presented on registered outputs with a valid/ready handshake.
//
//   State table (capture FSM)
//     state   | meaning
//     ST_IDLE | waiting for a rising edge on i_byte_strobe
//     ST_ACK  | byte taken; o_byte_clear high until i_byte_strobe falls
//
// Ports
//   game_clk           clock
//   reset_n            synchronous active-low reset
//   i_byte_in[7:0]     SPI data byte, stable while i_byte_strobe is high
//   i_byte_strobe      SPI data_valid, already synchronized to game_clk
//   o_byte_clear       clear back to the SPI block
//   o_cmd_valid        head entry available
//   i_cmd_ready        executioner takes the head this cycle
//   o_cmd_move[1:0]    head byte[1:0]
//   o_cmd_move_valid   head byte[5]
//   o_cmd_piece[2:0]   head byte[4:2], piece 7 remapped to 0 (HERO)
//   o_occupancy        number of entries held
//   o_overflow_count   bytes dropped on a full FIFO, saturating
module tetris_command_queue #(
   parameter int          DEPTH      = 4,
   parameter int          DROP_CNT_W = 8,
   parameter logic [7:0]  FLUSH_BYTE = 8'hFF
) (
   input  logic                         game_clk,
   input  logic                         reset_n,
   input  logic [7:0]                   i_byte_in,
   input  logic                         i_byte_strobe,
   output logic                         o_byte_clear,
   output logic                         o_cmd_valid,
   input  logic                         i_cmd_ready,
   output logic [1:0]                   o_cmd_move,
   output logic                         o_cmd_move_valid,
   output logic [2:0]                   o_cmd_piece,
   output logic [$clog2(DEPTH+1)-1:0]   o_occupancy,
   output logic [DROP_CNT_W-1:0]        o_overflow_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH+1);

   typedef enum logic {ST_IDLE, ST_ACK} state_t;

   state_t                r_state;
   state_t                w_state_next;
   logic                  r_strobe_d;
   logic [5:0]            r_mem [DEPTH];
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [OCC_W-1:0]      r_occ;
   logic [5:0]            r_head;
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   logic                  w_new_byte;
   logic                  w_flush;
   logic                  w_full;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_drop;
   logic [2:0]            w_piece;
   logic [5:0]            w_push_data;
   logic [PTR_W-1:0]      w_rd_ptr_next;
   logic [OCC_W-1:0]      w_occ_next;
   logic [5:0]            w_head_next;

   // Edges arriving while in ST_ACK are deliberately ignored.
   assign w_new_byte  = (r_state == ST_IDLE) & i_byte_strobe & ~r_strobe_d;
   assign w_flush     = w_new_byte & (i_byte_in == FLUSH_BYTE);
   assign w_full      = (r_occ == OCC_W'(DEPTH));
   // A flush discards any pop requested in the same cycle.
   assign w_pop       = o_cmd_valid & i_cmd_ready & ~w_flush;
   assign w_push      = w_new_byte & ~w_flush & (~w_full | w_pop);
   assign w_drop      = w_new_byte & ~w_flush & w_full & ~w_pop;
   assign w_piece     = (i_byte_in[4:2] == 3'd7) ? 3'd0 : i_byte_in[4:2];
   assign w_push_data = {i_byte_in[5], w_piece, i_byte_in[1:0]};

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_new_byte)     w_state_next = ST_ACK;
         ST_ACK:  if (!i_byte_strobe) w_state_next = ST_IDLE;
         default:                     w_state_next = ST_IDLE;
      endcase
   end

   // The head register is the FWFT output stage. It loads the pushed entry
   // directly when the FIFO would otherwise be empty, otherwise the entry
   // behind the one being popped, and holds its value when nothing changes.
   always_comb begin
      w_rd_ptr_next = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
      w_occ_next    = r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
      w_head_next   = r_head;
      if (w_push && (r_occ == OCC_W'(w_pop)))
         w_head_next = w_push_data;
      else if (w_pop && (r_occ > OCC_W'(1)))
         w_head_next = r_mem[w_rd_ptr_next];
   end

   always_ff @(posedge game_clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_strobe_d <= 1'b1;   // a strobe held across reset must not look like a new edge
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_occ      <= '0;
         r_head     <= '0;
         r_drop_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_strobe_d <= i_byte_strobe;
         if (w_flush) begin
            r_occ    <= '0;
            r_rd_ptr <= r_wr_ptr;
         end else begin
            r_occ    <= w_occ_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_head   <= w_head_next;
            if (w_push)
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   // Storage needs no reset; pointers and occupancy define what is valid.
   always_ff @(posedge game_clk) begin
      if (reset_n && w_push)
         r_mem[r_wr_ptr] <= w_push_data;
   end

   assign o_byte_clear     = (r_state == ST_ACK);
   assign o_cmd_valid      = (r_occ != '0);
   assign o_cmd_move       = r_head[1:0];
   assign o_cmd_piece      = r_head[4:2];
   assign o_cmd_move_valid = r_head[5];
   assign o_occupancy      = r_occ;
   assign o_overflow_count = r_drop_cnt;

endmodule
